// File: rtl/arbt_pkg.sv
// Shared types and helpers for the round-robin arbiter family.
package arbt_pkg;

  localparam int unsigned ARBT_WIDTH_DEF = 4;
  localparam int unsigned WGHT_MAX_BITS  = 16;

  typedef logic [$clog2(ARBT_WIDTH_DEF)-1:0] arbt_idx_t;

  // Index width for an n-way arbiter, never narrower than one bit.
  function automatic int unsigned arbt_idx_bits(input int unsigned n);
    if (n > 32'd2) return $clog2(n);
    else return 32'd1;
  endfunction

  function automatic logic [WGHT_MAX_BITS-1:0] arbt_eff_weight(input logic [WGHT_MAX_BITS-1:0] w);
    if (w == 16'd0) return 16'd1;
    else return w;
  endfunction

endpackage

// File: rtl/arbt_rr_sel.sv
// Rotating-priority selector: first requester after last_i wins, last_i itself is lowest.
module arbt_rr_sel #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] sel_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand_s;

  // Scan from the farthest slot to the nearest so the nearest requester overrides.
  always_comb begin
    sel_o  = last_i;
    cand_s = last_i;
    for (int k = int'(N); k >= 1; k--) begin
      cand_s = last_i + IDX_W'(k);
      sel_o  = req_i[cand_s] ? cand_s : sel_o;
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/arbt_wrr_chk.sv
// Protocol and state invariants for arbt_wrr.
module arbt_wrr_chk #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ARBT_WIDTH = 4,
  parameter int unsigned WGHT_WIDTH = 4
) (
  input logic                          clk_i,
  input logic                          rst_i,
  input logic [ARBT_WIDTH-1:0]         req_i,
  input logic [ARBT_WIDTH-1:0]         gnt_i,
  input logic [DATA_WIDTH-1:0]         data_i,
  input logic [$clog2(ARBT_WIDTH)-1:0] idx_i,
  input logic                          vld_i,
  input logic                          ack_i,
  input logic [WGHT_WIDTH-1:0]         burst_cnt_i
);

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(gnt_i));

  a_gnt_req: assert property (@(posedge clk_i) disable iff (rst_i)
    (gnt_i & ~req_i) == {ARBT_WIDTH{1'b0}});

  a_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (vld_i && !ack_i) |=> ($stable(data_i) && $stable(idx_i)));

  a_burst_range: assert property (@(posedge clk_i) disable iff (rst_i)
    {1'b0, burst_cnt_i} < {1'b1, {WGHT_WIDTH{1'b0}}});

endmodule

// File: rtl/arbt_wrr.sv
// Weighted round-robin arbiter with a registered, back-pressured output stage.
module arbt_wrr
  import arbt_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ARBT_WIDTH = 4,
  parameter int unsigned            WGHT_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0]  RESET_VAL  = {DATA_WIDTH{1'b0}}
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DATA_WIDTH-1:0]         data_i   [0:ARBT_WIDTH-1],
  input  logic [ARBT_WIDTH-1:0]         req_i,
  output logic [ARBT_WIDTH-1:0]         gnt_o,
  input  logic [WGHT_WIDTH-1:0]         weight_i [0:ARBT_WIDTH-1],
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic [$clog2(ARBT_WIDTH)-1:0] idx_o,
  output logic                          vld_o,
  input  logic                          ack_i
);

  localparam int unsigned IDX_W = arbt_idx_bits(ARBT_WIDTH);

  logic [IDX_W-1:0]         cur_idx_q, cur_idx_d;
  logic [WGHT_WIDTH-1:0]    burst_cnt_q, burst_cnt_d;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     vld_q;
  logic [IDX_W-1:0]         scan_sel_s, sel_s;
  logic                     any_s, cont_s, take_s;
  logic [WGHT_MAX_BITS-1:0] eff_w_s;

  arbt_rr_sel #(
    .N     (ARBT_WIDTH),
    .IDX_W (IDX_W)
  ) u_rr_sel (
    .req_i  (req_i),
    .last_i (cur_idx_q),
    .sel_o  (scan_sel_s),
    .any_o  (any_s)
  );

  // Winner selection and burst/pointer next state; a stalled stage freezes both.
  always_comb begin
    cont_s      = (burst_cnt_q != {WGHT_WIDTH{1'b0}}) && req_i[cur_idx_q];
    sel_s       = cont_s ? cur_idx_q : scan_sel_s;
    take_s      = (!vld_q || ack_i) && any_s;
    eff_w_s     = arbt_eff_weight(WGHT_MAX_BITS'(weight_i[sel_s]));
    cur_idx_d   = cur_idx_q;
    burst_cnt_d = burst_cnt_q;
    if (take_s && cont_s) begin
      burst_cnt_d = burst_cnt_q - WGHT_WIDTH'(1);
    end else if (take_s) begin
      cur_idx_d   = sel_s;
      burst_cnt_d = WGHT_WIDTH'(eff_w_s - 16'd1);
    end else begin
      cur_idx_d   = cur_idx_q;
      burst_cnt_d = burst_cnt_q;
    end
  end

  // Accept strobe toward the winning requester, held low while in reset.
  always_comb begin
    gnt_o = {ARBT_WIDTH{1'b0}};
    if (take_s && !rst_i) begin
      gnt_o[sel_s] = 1'b1;
    end else begin
      gnt_o = {ARBT_WIDTH{1'b0}};
    end
  end

  // Arbitration state and output register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_idx_q   <= IDX_W'(ARBT_WIDTH - 1);
      burst_cnt_q <= {WGHT_WIDTH{1'b0}};
      data_q      <= RESET_VAL;
      idx_q       <= {IDX_W{1'b0}};
      vld_q       <= 1'b0;
    end else begin
      cur_idx_q   <= cur_idx_d;
      burst_cnt_q <= burst_cnt_d;
      if (take_s) begin
        data_q <= data_i[sel_s];
        idx_q  <= sel_s;
        vld_q  <= 1'b1;
      end else if (ack_i) begin
        vld_q <= 1'b0;
      end else begin
        vld_q <= vld_q;
      end
    end
  end

  assign data_o = data_q;
  assign idx_o  = idx_q;
  assign vld_o  = vld_q;

endmodule

// File: tb/tb_arbt_wrr.sv
// Self-checking bench for arbt_wrr: directed scenarios plus random traffic against a queue-free reference model.
module tb_arbt_wrr;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] data_s   [0:3];
  logic [3:0]  weight_s [0:3];
  logic [3:0]  req_s;
  logic        ack_s;
  logic [3:0]  gnt_o;
  logic [31:0] data_o;
  logic [1:0]  idx_o;
  logic        vld_o;

  int checks = 0;
  int errors = 0;

  // reference model: who owns the pointer and how many bonus grants remain
  int          m_owner;
  int          m_left;
  logic        m_vld;
  logic [31:0] m_data;
  int          m_idx;
  int          last_win;

  arbt_wrr #(
    .DATA_WIDTH (32),
    .ARBT_WIDTH (4),
    .WGHT_WIDTH (4)
  ) u_dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_s),
    .req_i    (req_s),
    .gnt_o    (gnt_o),
    .weight_i (weight_s),
    .data_o   (data_o),
    .idx_o    (idx_o),
    .vld_o    (vld_o),
    .ack_i    (ack_s)
  );

  arbt_wrr_chk #(
    .DATA_WIDTH (32),
    .ARBT_WIDTH (4),
    .WGHT_WIDTH (4)
  ) u_chk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_s),
    .gnt_i       (gnt_o),
    .data_i      (data_o),
    .idx_i       (idx_o),
    .vld_i       (vld_o),
    .ack_i       (ack_s),
    .burst_cnt_i (u_dut.burst_cnt_q)
  );

  initial forever #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 3;
    m_left  = 0;
    m_vld   = 1'b0;
    m_data  = 32'd0;
    m_idx   = 0;
  endtask

  // The owner keeps winning while it has bonus grants and still asks; otherwise
  // the first asker after the owner (cyclically, owner last) starts a new burst.
  task automatic model_pick(input logic [3:0] req, output int win);
    int w;
    win = -1;
    if (m_left > 0 && req[m_owner]) begin
      win = m_owner;
      m_left = m_left - 1;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        if (win < 0 && req[(m_owner + k) % 4]) win = (m_owner + k) % 4;
      end
      w = int'(weight_s[win]);
      if (w == 0) w = 1;
      m_owner = win;
      m_left  = w - 1;
    end
  endtask

  // One clock: check the combinational grant, then the registered outputs.
  task automatic cycle();
    logic take;
    int   win;
    #1;
    take = (!m_vld || ack_s) && (req_s != 4'b0000);
    win  = -1;
    if (take) model_pick(req_s, win);
    chk("gnt", 32'(gnt_o), take ? (32'd1 << win) : 32'd0);
    @(posedge clk_i);
    if (take) begin
      m_vld  = 1'b1;
      m_data = data_s[win];
      m_idx  = win;
    end else if (ack_s) begin
      m_vld = 1'b0;
    end
    #1;
    chk("vld", 32'(vld_o), 32'(m_vld));
    chk("idx", 32'(idx_o), 32'(m_idx));
    chk("data", data_o, m_data);
    last_win = win;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("rst_vld", 32'(vld_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_idx", 32'(idx_o), 32'd0);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    weight_s[0] = 4'(w0);
    weight_s[1] = 4'(w1);
    weight_s[2] = 4'(w2);
    weight_s[3] = 4'(w3);
  endtask

  initial begin
    int seq2 [10] = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 1};
    int seq4 [5]  = '{0, 0, 1, 3, 0};
    int seq5 [8]  = '{0, -1, -1, -1, -1, -1, 0, 0};
    rst_i = 1'b1;
    req_s = 4'b0000;
    ack_s = 1'b0;
    set_w(1, 1, 1, 1);
    for (int k = 0; k < 4; k++) data_s[k] = $urandom;
    model_reset();
    last_win = -1;
    @(negedge clk_i);
    do_reset();

    // plain round robin, one transfer per cycle
    req_s = 4'b1111;
    ack_s = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("t1_seq", 32'(last_win), 32'(i % 4));
    end

    // weight 3 on requester 0
    do_reset();
    set_w(3, 1, 1, 1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t2_seq", 32'(last_win), 32'(seq2[i]));
    end

    // weight 0 behaves as 1
    do_reset();
    set_w(1, 1, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("t3_seq", 32'(last_win), 32'(i % 4));
    end

    // owner drops its request mid-burst
    do_reset();
    set_w(4, 1, 1, 1);
    req_s = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) req_s = 4'b1010;
      if (i == 4) req_s = 4'b1011;
      cycle();
      chk("t4_seq", 32'(last_win), 32'(seq4[i]));
    end

    // back-pressure freezes arbitration and the burst
    do_reset();
    set_w(3, 1, 1, 1);
    req_s = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      ack_s = (i >= 1 && i <= 5) ? 1'b0 : 1'b1;
      cycle();
      chk("t5_seq", 32'(last_win), 32'(seq5[i]));
    end
    ack_s = 1'b1;
    cycle();
    chk("t5_next", 32'(last_win), 32'd1);

    // asynchronous reset in the middle of a burst
    do_reset();
    cycle();
    cycle();
    rst_i = 1'b1;
    #1;
    chk("t6_vld", 32'(vld_o), 32'd0);
    chk("t6_data", data_o, 32'd0);
    chk("t6_gnt", 32'(gnt_o), 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    cycle();
    chk("t6_first", 32'(last_win), 32'd0);

    // random traffic following the requester protocol
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) begin
        for (int k = 0; k < 4; k++) weight_s[k] = 4'($urandom_range(0, 15));
      end
      ack_s = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
      cycle();
      if (last_win >= 0) begin
        data_s[last_win] = $urandom;
        req_s[last_win]  = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
        if (!req_s[k] && k != last_win) req_s[k] = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
